// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the multi-channel MAC engine.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FINAL,
    DONE
  } mac_state_t;

  // Default geometry of the digit-recognition layer.
  localparam int DEF_BITS     = 24;
  localparam int DEF_WIDTH    = 784;
  localparam int CNT_W        = $clog2(DEF_WIDTH + 1);
  localparam int ACC_BITS_DEF = 2 * DEF_BITS + $clog2(DEF_WIDTH);

  // Container wide enough for any post-accumulation intermediate.
  localparam int MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;

  // Interpret the low in_width bits of value as signed, then clamp to
  // the signed range of out_width bits.
  function automatic wide_t sat_trunc(input wide_t value, input int in_width,
                                      input int out_width);
    wide_t v;
    wide_t hi;
    wide_t lo;
    v  = (value <<< (MAX_W - in_width)) >>> (MAX_W - in_width);
    hi = (wide_t'(1) <<< (out_width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (out_width - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  // Clamp negative values to zero when enabled.
  function automatic wide_t relu(input wide_t value, input logic en);
    if (en && (value < 0)) begin
      return '0;
    end
    return value;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC channel: product register, accumulator, bias/saturate/ReLU result.
// Latency: product 1 cycle after p_en, accumulate 1 cycle later, result on fin_en.
// Backpressure: none; the controlling FSM gates every enable.
module mac_lane
  import mac_pkg::*;
#(
  parameter int BITS     = 24,
  parameter int FRAC     = 12,
  parameter int ACC_BITS = 58
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   p_en,
  input  logic                   acc_en,
  input  logic                   fin_en,
  input  logic                   relu_en,
  input  logic signed [BITS-1:0] din,
  input  logic signed [BITS-1:0] w,
  input  logic signed [BITS-1:0] bias,
  output logic        [BITS-1:0] result
);

  logic signed [2*BITS-1:0]   prod;
  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS:0]   r_wide;
  logic        [BITS-1:0]     r_fin;

  // Full-precision product of the accepted beat.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prod <= '0;
    end else if (p_en) begin
      prod <= din * w;
    end
  end

  // Accumulate the registered product one cycle behind the handshake.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + (ACC_BITS)'(prod);
    end
  end

  // Rescale to the operand Q format (floor), add bias, clamp, optional ReLU.
  always_comb begin
    r_wide = (ACC_BITS + 1)'(acc >>> FRAC) + (ACC_BITS + 1)'(bias);
    r_fin  = BITS'(relu(sat_trunc(wide_t'(r_wide), ACC_BITS + 1, BITS), relu_en));
  end

  // Result register holds until the next transaction clears it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      result <= '0;
    end else if (fin_en) begin
      result <= r_fin;
    end
  end

endmodule

// File: rtl/mac_array.sv
// N_CH-lane fixed-point MAC engine over one streamed pixel vector per transaction.
// Latency: done 3 cycles after the last accepted beat (start + WIDTH + 3 gap-free).
// Backpressure: din_ready only in RUN; din_valid gaps stall without effect.
module mac_array
  import mac_pkg::*;
#(
  parameter int BITS     = 24,
  parameter int FRAC     = 12,
  parameter int N_CH     = 10,
  parameter int WIDTH    = 784,
  parameter int ACC_BITS = 2 * BITS + $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 relu_en,
  input  logic [N_CH*BITS-1:0] bias_in,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [BITS-1:0]      din,
  input  logic [N_CH*BITS-1:0] w_in,
  output logic                 busy,
  output logic                 done,
  output logic [N_CH*BITS-1:0] dout
);

  localparam int CW = $clog2(WIDTH + 1);

  mac_state_t state;
  mac_state_t nxt;

  logic [CW-1:0]        cnt;
  logic                 p_valid;
  logic [N_CH*BITS-1:0] bias_q;
  logic                 relu_q;
  logic                 accept;
  logic                 last_beat;
  logic                 clear;
  logic                 fin_en;

  assign accept    = din_valid && din_ready;
  assign last_beat = accept && (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic: one pass through the pipeline per transaction.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last_beat) nxt = DRAIN;
      DRAIN:   nxt = FINAL;
      FINAL:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Decoded outputs and lane controls.
  always_comb begin
    din_ready = (state == RUN);
    busy      = (state == RUN) || (state == DRAIN) || (state == FINAL);
    done      = (state == DONE);
    clear     = (state == IDLE) && start;
    fin_en    = (state == FINAL);
  end

  // Beat counter and product-valid flag for the accumulate stage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt     <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Bias and ReLU mode are captured once, on the start accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q <= '0;
      relu_q <= 1'b0;
    end else if (clear) begin
      bias_q <= bias_in;
      relu_q <= relu_en;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    mac_lane #(
      .BITS    (BITS),
      .FRAC    (FRAC),
      .ACC_BITS(ACC_BITS)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .p_en   (accept),
      .acc_en (p_valid),
      .fin_en (fin_en),
      .relu_en(relu_q),
      .din    (din),
      .w      (w_in[k*BITS +: BITS]),
      .bias   (bias_q[k*BITS +: BITS]),
      .result (dout[k*BITS +: BITS])
    );
  end

endmodule
